// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: centisecond stopwatch, SS.cc from 00.00 to 59.99 in BCD.
// clk_100 is synchronized and edge-detected into a one-cycle tick in the clk domain.
// Buttons are debounced levels; each rising edge acts once.
//
// Ports:
//   clk        system clock (the only clock)
//   reset      synchronous, active-high
//   clk_100    100 Hz square wave, asynchronous, used as data
//   btn_start  rising edge toggles run/pause
//   btn_clear  rising edge zeroes the count and returns to IDLE
//   btn_lap    rising edge toggles lap hold (only with STOPWATCH_LAP_EN)
//   sec_tens, sec_ones, cs_tens, cs_ones   BCD digit outputs
//   running    high while in RUN (registered)
//   wrap       one-cycle pulse after rollover from 59.99 to 00.00
//
// Build option: define STOPWATCH_LAP_EN to enable the lap-hold snapshot.
module stopwatch_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_100,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] cs_ones,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state_q, state_d;
    logic       s1, s2, s_prev, tick;
    // Each button is sampled once, then compared with its history flop, so an
    // edge sampled at edge M is acted on at edge M+1.
    logic       start_s, start_h, clear_s, clear_h;
    logic       start_edge, clear_edge;
    logic [3:0] st_q, so_q, ct_q, co_q;
    logic [3:0] st_d, so_d, ct_d, co_d;
    logic       wrap_d;

    assign tick       = s2 & ~s_prev;
    assign start_edge = start_s & ~start_h;
    assign clear_edge = clear_s & ~clear_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s_prev  <= 1'b0;
            start_s <= 1'b0;
            start_h <= 1'b0;
            clear_s <= 1'b0;
            clear_h <= 1'b0;
            state_q <= IDLE;
            st_q    <= '0;
            so_q    <= '0;
            ct_q    <= '0;
            co_q    <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            s1      <= clk_100;
            s2      <= s1;
            s_prev  <= s2;
            start_s <= btn_start;
            start_h <= start_s;
            clear_s <= btn_clear;
            clear_h <= clear_s;
            state_q <= state_d;
            st_q    <= st_d;
            so_q    <= so_d;
            ct_q    <= ct_d;
            co_q    <= co_d;
            running <= (state_d == RUN);
            wrap    <= wrap_d;
        end
    end

    // Next state: clear beats start.
    always_comb begin
        state_d = state_q;
        if (clear_edge) begin
            state_d = IDLE;
        end else if (start_edge) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // BCD ripple counter. Counting keys off the current state, so a tick on
    // the RUN->PAUSE edge counts and one on the PAUSE->RUN edge does not.
    // Out-of-range digits compare as >= their wrap value, i.e. they carry.
    always_comb begin
        st_d   = st_q;
        so_d   = so_q;
        ct_d   = ct_q;
        co_d   = co_q;
        wrap_d = 1'b0;
        if (clear_edge) begin
            st_d = '0;
            so_d = '0;
            ct_d = '0;
            co_d = '0;
        end else if (tick && (state_q == RUN)) begin
            if (co_q >= 4'd9) begin
                co_d = '0;
                if (ct_q >= 4'd9) begin
                    ct_d = '0;
                    if (so_q >= 4'd9) begin
                        so_d = '0;
                        if (st_q >= 4'd5) begin
                            st_d   = '0;
                            wrap_d = 1'b1;
                        end else begin
                            st_d = st_q + 4'd1;
                        end
                    end else begin
                        so_d = so_q + 4'd1;
                    end
                end else begin
                    ct_d = ct_q + 4'd1;
                end
            end else begin
                co_d = co_q + 4'd1;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_s, lap_h, lap_edge, hold_q;
    logic [3:0] snap_st, snap_so, snap_ct, snap_co;

    assign lap_edge = lap_s & ~lap_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_s   <= 1'b0;
            lap_h   <= 1'b0;
            hold_q  <= 1'b0;
            snap_st <= '0;
            snap_so <= '0;
            snap_ct <= '0;
            snap_co <= '0;
        end else begin
            lap_s <= btn_lap;
            lap_h <= lap_s;
            if (clear_edge) begin
                hold_q <= 1'b0;
            end else if (lap_edge && (state_q != IDLE)) begin
                hold_q <= ~hold_q;
                // Snapshot is the count showing when hold is set.
                if (!hold_q) begin
                    snap_st <= st_q;
                    snap_so <= so_q;
                    snap_ct <= ct_q;
                    snap_co <= co_q;
                end
            end
        end
    end

    always_comb begin
        sec_tens = hold_q ? snap_st : st_q;
        sec_ones = hold_q ? snap_so : so_q;
        cs_tens  = hold_q ? snap_ct : ct_q;
        cs_ones  = hold_q ? snap_co : co_q;
    end
`else
    logic unused_lap;
    assign unused_lap = btn_lap;

    always_comb begin
        sec_tens = st_q;
        sec_ones = so_q;
        cs_tens  = ct_q;
        cs_ones  = co_q;
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset, clk_100, btn_start, btn_clear, btn_lap;
    logic [3:0] sec_tens, sec_ones, cs_tens, cs_ones;
    logic       running, wrap;

    stopwatch_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .clk_100  (clk_100),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .btn_lap  (btn_lap),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .cs_tens  (cs_tens),
        .cs_ones  (cs_ones),
        .running  (running),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed time as an integer number of centiseconds,
    // mode 0 idle / 1 run / 2 pause, inputs kept as delay lines of samples.
    int m_cnt, m_mode, m_hold, m_snap, m_wrap;
    int c_h[1:3];
    int s_h[1:2], cl_h[1:2], l_h[1:2];

    function automatic logic [17:0] pack(int v, bit r, bit w);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), r, w};
    endfunction

    function automatic logic [17:0] actual();
        return {sec_tens, sec_ones, cs_tens, cs_ones, running, wrap};
    endfunction

    task automatic check(string name, logic [17:0] got, logic [17:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h (ss.cc/run/wrap) required %h", name, got, exp);
    endtask

    task automatic model_step();
        int old;
        bit tk, se, ce, le;
        if (reset) begin
            m_cnt = 0; m_mode = 0; m_hold = 0; m_snap = 0; m_wrap = 0;
            c_h = '{0, 0, 0};
            s_h = '{0, 0}; cl_h = '{0, 0}; l_h = '{0, 0};
            return;
        end
        // clk_100 sampled high at edge N is counted at edge N+2;
        // a button sampled high at edge M acts at edge M+1.
        tk = (c_h[2] == 1) && (c_h[3] == 0);
        se = (s_h[1] == 1) && (s_h[2] == 0);
        ce = (cl_h[1] == 1) && (cl_h[2] == 0);
        le = (l_h[1] == 1) && (l_h[2] == 0);
        m_wrap = 0;
        old = m_cnt;
        if (ce) begin
            m_cnt = 0; m_mode = 0; m_hold = 0;
        end else begin
            if (m_mode == 1 && tk) begin
                m_cnt  = (m_cnt + 1) % 6000;
                m_wrap = (old == 5999);
            end
`ifdef STOPWATCH_LAP_EN
            if (m_mode != 0 && le) begin
                if (m_hold == 0) begin m_hold = 1; m_snap = old; end
                else m_hold = 0;
            end
`endif
            if (se) m_mode = (m_mode == 1) ? 2 : 1;
        end
        c_h[3] = c_h[2]; c_h[2] = c_h[1]; c_h[1] = clk_100;
        s_h[2] = s_h[1];  s_h[1] = btn_start;
        cl_h[2] = cl_h[1]; cl_h[1] = btn_clear;
        l_h[2] = l_h[1];  l_h[1] = btn_lap;
    endtask

    function automatic logic [17:0] model_out();
        return pack((m_hold != 0) ? m_snap : m_cnt, m_mode == 1, m_wrap != 0);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model", actual(), model_out());
    endtask

    task automatic tick_n(int n);
        for (int i = 0; i < n; i++) begin
            clk_100 = 1'b1; cyc(); cyc();
            clk_100 = 1'b0; cyc(); cyc();
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1; cyc(); cyc();
        btn_start = 1'b0; cyc();
    endtask

    typedef struct {
        bit          rst, c100, start, clear, lap;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        reset = 1'b1; clk_100 = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;

        // Cycle-exact vectors from reset: spurious tick in IDLE, start, two
        // counted ticks, then a clear.
        vecs[0]  = '{1, 0, 0, 0, 0, pack(0, 0, 0)};
        vecs[1]  = '{1, 1, 0, 0, 0, pack(0, 0, 0)};
        vecs[2]  = '{0, 1, 0, 0, 0, pack(0, 0, 0)};
        vecs[3]  = '{0, 1, 0, 0, 0, pack(0, 0, 0)};
        vecs[4]  = '{0, 0, 1, 0, 0, pack(0, 0, 0)};
        vecs[5]  = '{0, 0, 1, 0, 0, pack(0, 1, 0)};
        vecs[6]  = '{0, 1, 0, 0, 0, pack(0, 1, 0)};
        vecs[7]  = '{0, 1, 0, 0, 0, pack(0, 1, 0)};
        vecs[8]  = '{0, 0, 0, 0, 0, pack(1, 1, 0)};
        vecs[9]  = '{0, 0, 0, 0, 0, pack(1, 1, 0)};
        vecs[10] = '{0, 1, 0, 0, 0, pack(1, 1, 0)};
        vecs[11] = '{0, 1, 0, 0, 0, pack(1, 1, 0)};
        vecs[12] = '{0, 0, 0, 1, 1, pack(2, 1, 0)};
        vecs[13] = '{0, 0, 0, 1, 1, pack(0, 0, 0)};
        vecs[14] = '{0, 0, 0, 0, 0, pack(0, 0, 0)};
        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst; clk_100 = vecs[i].c100;
            btn_start = vecs[i].start; btn_clear = vecs[i].clear; btn_lap = vecs[i].lap;
            cyc();
            check($sformatf("vec%0d", i), actual(), vecs[i].exp);
        end
        reset = 1'b0; clk_100 = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        cyc(); cyc();

        // Tick latency: unchanged at N and N+1, incremented at N+2.
        press_start();
        clk_100 = 1'b1; cyc(); check("lat_n", actual(), pack(0, 1, 0));
        cyc();                 check("lat_n1", actual(), pack(0, 1, 0));
        clk_100 = 1'b0; cyc(); check("lat_n2", actual(), pack(1, 1, 0));
        cyc();
        tick_n(249);
        check("run_250", actual(), pack(250, 1, 0));

        // Pause holds the count; resume counts again.
        tick_n(67);
        check("at_317", actual(), pack(317, 1, 0));
        press_start();
        tick_n(5);
        check("paused", actual(), pack(317, 0, 0));
        press_start();
        tick_n(1);
        check("resumed", actual(), pack(318, 1, 0));

        // Lap hold.
        tick_n(102);
        btn_lap = 1'b1; cyc(); cyc(); btn_lap = 1'b0; cyc();
        tick_n(30);
`ifdef STOPWATCH_LAP_EN
        check("lap_hold", actual(), pack(420, 1, 0));
`else
        check("lap_hold", actual(), pack(450, 1, 0));
`endif
        btn_lap = 1'b1; cyc(); cyc();
        check("lap_release", actual(), pack(450, 1, 0));
        btn_lap = 1'b0; cyc();

        // Clear and tick landing on the same edge at 12.34.
        tick_n(784);
        check("at_1234", actual(), pack(1234, 1, 0));
        clk_100 = 1'b1; cyc();
        btn_clear = 1'b1; cyc();
        cyc();
        check("clear_tick", actual(), pack(0, 0, 0));
        btn_clear = 1'b0; clk_100 = 1'b0; cyc(); cyc();

        // Reset mid-count abandons the count; no counting until a new start.
        press_start();
        tick_n(10);
        check("pre_reset", actual(), pack(10, 1, 0));
        reset = 1'b1; cyc(); reset = 1'b0;
        check("mid_reset", actual(), pack(0, 0, 0));
        tick_n(3);
        check("post_reset", actual(), pack(0, 0, 0));

        // Rollover 59.99 -> 00.00 with a single-cycle wrap.
        press_start();
        tick_n(5998);
        check("at_5998", actual(), pack(5998, 1, 0));
        tick_n(1);
        check("at_5999", actual(), pack(5999, 1, 0));
        clk_100 = 1'b1; cyc(); cyc();
        clk_100 = 1'b0; cyc();
        check("wrap_pulse", actual(), pack(0, 1, 1));
        cyc();
        check("wrap_end", actual(), pack(0, 1, 0));

        // Clear and start together from IDLE stay in IDLE.
        btn_clear = 1'b1; cyc(); cyc(); btn_clear = 1'b0; cyc();
        btn_start = 1'b1; btn_clear = 1'b1; cyc(); cyc();
        check("clear_start", actual(), pack(0, 0, 0));
        btn_start = 1'b0; btn_clear = 1'b0; cyc();

        // Random stimulus against the model.
        begin
            int half = 2;
            for (int i = 0; i < 6000; i++) begin
                reset = ($urandom_range(0, 799) == 0);
                if (--half == 0) begin
                    clk_100 = ~clk_100;
                    half = $urandom_range(1, 4);
                end
                if ($urandom_range(0, 29) == 0) btn_start = ~btn_start;
                if ($urandom_range(0, 199) == 0) btn_clear = ~btn_clear;
                if ($urandom_range(0, 59) == 0) btn_lap = ~btn_lap;
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
